seq_pattern_detector: RTL
=========================

Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-state Mealy pattern FSM.
- Pattern and length are runtime-programmable (1..MAX_LEN bits), with selectable overlapping/non-overlapping detection, a valid-qualified input and a saturating match counter.
- Sits on a serial bit stream, e.g. a frame/sync-word detector ahead of a deserialiser; z pulse flags the final bit of each detected pattern.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state when 0.
- cfg_load  input  1  one-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit 0 the last.
- cfg_len  input  LEN_W  pattern length; legal 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history restarts after each match.
- enable  input  1  detector active; 0 ignores input bits, holds state.
- in_valid  input  1  in is a new bit this cycle.
- in  input  1  serial data bit.
- z  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  saturating count of matches since reset/cfg_load.
- busy  output  1  1 while a partial match is in progress (fill>0 and no match this cycle).

Behaviour:
- Reset (reset=0, async): hist=0, fill=0, pat=0, len=1, overlap=1, z=0, match_count=0, busy=0. Released synchronously to clk; first bit accepted on first edge with reset=1.
- Config: on cfg_load=1, pat/len/overlap register the inputs; hist, fill, match_count cleared; z=0 next cycle. cfg_len=0 or >MAX_LEN clamps to MAX_LEN.
- Accept: bit accepted iff enable=1, in_valid=1, cfg_load=0. cfg_load wins over a simultaneous bit (bit discarded, no match).
- On accept: hist_n={hist[MAX_LEN-2:0],in} (newest bit at LSB); fill_n=min(fill+1,MAX_LEN).
- Match: m = accept && fill_n>=len && hist_n[len-1:0]==pat[len-1:0] (upper bits ignored).
- Latency: z=1 on the clock edge after the edge that samples the last pattern bit, for exactly one cycle; z=0 every other cycle, including cycles with no accept.
- Overlap=1: after match, hist/fill continue (fill saturates at MAX_LEN); suffix bits reusable.
- Overlap=0: after match, fill=0 on the same edge; next match needs len fresh bits.
- match_count increments on the same edge z is set; saturates at 2^CNT_W-1, never wraps.
- busy=1 when fill>0 and hist[fill-1:0] is a proper prefix of pattern (i.e., some partial alignment); simplification allowed: busy=(fill>0)&&!z-cycle. Implement the simple form.
- enable=0: no shift, no match, z=0; hist/fill/count held.
- Gaps (in_valid=0) between bits do not break a match.
- Reset mid-stream: everything cleared immediately, including config; partial matches lost.

Test Plan:
- pattern=4'b1001, len=4, overlap=1; bits 1,0,0,1,0,0,1 -> z pulses one cycle after 4th and 7th bits; match_count=2.
- Same stream, overlap=0 -> z only after 4th bit; match_count=1; next 1,0,0,1 -> second pulse.
- len=1, pattern=1, bits 1,1,0,1 with in_valid gaps -> z after each 1 only, count=3; no z in gap cycles.
- CNT_W=8, len=1, 300 accepted 1s -> match_count stops at 255, z keeps pulsing.
- cfg_load asserted with in_valid on final bit of 1001 -> no z, count=0, hist cleared; enable=0 mid-pattern holds partial, resume completes match.
- reset driven 0 asynchronously between edges mid-pattern -> z, count, busy 0 immediately; after release, len=1/pattern=0 defaults detect a single 0.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-programmable pattern and length,
// optional overlapping detection, and a saturating match counter.
module seq_pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               enable,
    input  logic               in_valid,
    input  logic               in,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               hit;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] len_mask;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        cnt_d     = cnt_q;
        z_d       = 1'b0;

        accept = enable && in_valid && !cfg_load;
        hist_n = {hist_q[MAX_LEN-2:0], in};
        fill_n = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);

        // Only the low len bits of history and pattern take part in the compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hit = accept && (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);

        if (cfg_load) begin
            pat_d     = cfg_pattern;
            len_d     = (cfg_len == '0 || cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            cnt_d     = '0;
        end else if (accept) begin
            hist_d = hist_n;
            fill_d = (hit && !overlap_q) ? '0 : fill_n;
            z_d    = hit;
            if (hit && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= LEN_W'(1);
            overlap_q <= 1'b1;
            z_q       <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            z_q       <= z_d;
            cnt_q     <= cnt_d;
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign busy        = (fill_q != '0) && !z_q;

endmodule
